// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the fmul issue/result path.
//   FP_W        : IEEE-754 single-precision word width
//   TAG_W_DEF   : default destination-register tag width
//   fmul_res_t  : packed result-FIFO entry {d, ovf, unf, tag} at the default tag width
//   RES_FIXED_W : entry width excluding the tag, used to size entries for other tag widths
package fpu_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned TAG_W_DEF = 5;

  typedef struct packed {
    logic [FP_W-1:0]      d;
    logic                 ovf;
    logic                 unf;
    logic [TAG_W_DEF-1:0] tag;
  } fmul_res_t;

  localparam int unsigned RES_FIXED_W = $bits(fmul_res_t) - TAG_W_DEF;

endpackage

// File: rtl/fpu_res_fifo.sv
// Result FIFO for the fmul issue controller.
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write one entry; caller guarantees the FIFO is never full on push
//   pop             : read request, ignored while empty
//   head            : entry at the read pointer
//   count           : occupancy, 0..DEPTH
module fpu_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 39,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_en;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_en = pop && (count != '0);

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_en)      count <= count + CNT_W'(1);
      else if (!push && pop_en) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: nothing is read before it is written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue/credit controller in front of a fixed-latency fmul pipeline.
// Requests are forwarded to the fmul combinationally; a valid/tag shift
// register tracks them for LAT cycles and the result is captured into a
// result FIFO. in_ready only grants a request when a FIFO slot is
// guaranteed for it, so the fmul output never has to stall.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   in_valid/in_ready          : request handshake; in_s, in_t operands, in_tag destination tag
//   fm_s, fm_t                 : operands to the fmul pipeline
//   fm_d, fm_ovf, fm_unf       : fmul result and flags, valid LAT cycles after fm_s/fm_t
//   out_valid/out_ready        : result handshake; out_d, out_tag, out_exc = {ovf, unf}
// Optional (macro FMUL_ISSUE_STICKY_EXC_EN):
//   exc_clr                    : clear sticky exception flags (wins over a same-cycle set)
//   exc_sticky                 : OR of out_exc over all popped results
module fmul_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_s,
  input  logic [FP_W-1:0]  in_t,
  input  logic [TAG_W-1:0] in_tag,
  output logic [FP_W-1:0]  fm_s,
  output logic [FP_W-1:0]  fm_t,
  input  logic [FP_W-1:0]  fm_d,
  input  logic             fm_ovf,
  input  logic             fm_unf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_d,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_exc
`ifdef FMUL_ISSUE_STICKY_EXC_EN
  ,
  input  logic             exc_clr,
  output logic [1:0]       exc_sticky
`endif
);

  localparam int unsigned ENT_W = RES_FIXED_W + TAG_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // fifo_count + in-flight count can reach DEPTH + LAT < 2*DEPTH
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             accept;
  logic             pop;
  logic [LAT-1:0]   vld_sr;
  logic [TAG_W-1:0] tag_sr [LAT];
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] committed;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head;

  assign fm_s   = in_s;
  assign fm_t   = in_t;
  assign accept = in_valid && in_ready;

  // Buffered plus in-flight results; each in-flight one already owns a slot
  always_comb begin
    committed = SUM_W'(fifo_count);
    for (int i = 0; i < int'(LAT); i++) begin
      committed = committed + SUM_W'(vld_sr[i]);
    end
  end

  assign in_ready = (committed < SUM_W'(DEPTH));

  // Valid tracking through the fmul pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_sr <= '0;
    else       vld_sr <= (vld_sr << 1) | LAT'(accept);
  end

  // Tags ride alongside; qualified by vld_sr so no reset is needed
  always_ff @(posedge clk) begin
    tag_sr[0] <= in_tag;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign push_data = {fm_d, fm_ovf, fm_unf, tag_sr[LAT-1]};
  assign pop       = out_valid && out_ready;

  fpu_res_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (vld_sr[LAT-1]),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);

  // Head is masked while empty so the outputs read zero out of reset
  assign {out_d, out_exc, out_tag} = out_valid ? head : ENT_W'(0);

`ifdef FMUL_ISSUE_STICKY_EXC_EN
  // Sticky exception accumulation over consumed results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        exc_sticky <= '0;
    else if (exc_clr) exc_sticky <= '0;
    else if (pop)     exc_sticky <= exc_sticky | out_exc;
  end
`endif

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed self-checking bench for fmul_issue_ctrl (TAG_W=5, LAT=1, DEPTH=4).
// A small behavioural fmul (truncating, normal operands only) stands in
// for the external pipeline with a LAT-cycle register stage.
module tb_fmul_issue_ctrl;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_s;
  logic [31:0]      in_t;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fm_s;
  logic [31:0]      fm_t;
  logic [31:0]      fm_d;
  logic             fm_ovf;
  logic             fm_unf;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_d;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_exc;
`ifdef FMUL_ISSUE_STICKY_EXC_EN
  logic             exc_clr;
  logic [1:0]       exc_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  fmul_issue_ctrl #(
    .TAG_W (TAG_W),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_t       (in_t),
    .in_tag     (in_tag),
    .fm_s       (fm_s),
    .fm_t       (fm_t),
    .fm_d       (fm_d),
    .fm_ovf     (fm_ovf),
    .fm_unf     (fm_unf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_tag    (out_tag),
    .out_exc    (out_exc)
`ifdef FMUL_ISSUE_STICKY_EXC_EN
    ,
    .exc_clr    (exc_clr),
    .exc_sticky (exc_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-precision multiply: returns {d, ovf, unf}
  function automatic logic [33:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'd0, 2'b00};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
    if (e <= 0)   return {s, 31'd0, 2'b01};
    return {s, 8'(e), m, 2'b00};
  endfunction

  // External fmul pipeline (one register stage for LAT=1)
  always @(posedge clk) begin
    {fm_d, fm_ovf, fm_unf} <= fmul_model(fm_s, fm_t);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] rnd;
  int          acc;

  initial begin
    fm_d      = '0;
    fm_ovf    = 1'b0;
    fm_unf    = 1'b0;
    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_s      = '0;
    in_t      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
`ifdef FMUL_ISSUE_STICKY_EXC_EN
    exc_clr   = 1'b0;
`endif

    // Reset state
    #1 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_d", out_d, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    chk("rst_count", 32'(dut.fifo_count), 32'd0);
`ifdef FMUL_ISSUE_STICKY_EXC_EN
    chk("rst_sticky", 32'(exc_sticky), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2.0 x 3.0, tag 3: result LAT+1 edges after acceptance
    in_valid  = 1'b1;
    in_s      = 32'h4000_0000;
    in_t      = 32'h4040_0000;
    in_tag    = 5'd3;
    out_ready = 1'b1;
    #1;
    chk("fm_s_pass", fm_s, 32'h4000_0000);
    chk("fm_t_pass", fm_t, 32'h4040_0000);
    tick;
    in_valid = 1'b0;
    chk("lat_not_early", 32'(out_valid), 32'd0);
    tick;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("mul_d", out_d, 32'h40C0_0000);
    chk("mul_tag", 32'(out_tag), 32'd3);
    chk("mul_exc", 32'(out_exc), 32'd0);
    tick;
    chk("mul_popped", 32'(out_valid), 32'd0);

    // Overflow: 0x7F000000 squared
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_s      = 32'h7F00_0000;
    in_t      = 32'h7F00_0000;
    in_tag    = 5'd5;
    tick;
    in_valid = 1'b0;
    tick;
    chk("ovf_valid", 32'(out_valid), 32'd1);
    chk("ovf_d", out_d, 32'h7F80_0000);
    chk("ovf_exc", 32'(out_exc), 32'h2);
    chk("ovf_tag", 32'(out_tag), 32'd5);
`ifdef FMUL_ISSUE_STICKY_EXC_EN
    chk("sticky_before_pop", 32'(exc_sticky), 32'd0);
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("ovf_popped", 32'(out_valid), 32'd0);
`ifdef FMUL_ISSUE_STICKY_EXC_EN
    chk("sticky_set", 32'(exc_sticky), 32'h2);
    exc_clr = 1'b1;
    tick;
    exc_clr = 1'b0;
    chk("sticky_clr", 32'(exc_sticky), 32'd0);
`endif

    // Back-pressure: exactly DEPTH accepted, then in_ready drops
    acc      = 0;
    in_valid = 1'b1;
    in_s     = 32'h3F80_0000;
    in_t     = 32'h3F80_0000;
    for (int i = 0; i < 8; i++) begin
      in_tag = 5'(10 + acc);
      #1;
      if (in_ready) acc++;
      tick;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(dut.fifo_count), 32'(DEPTH));
    out_ready = 1'b1;
    for (int j = 0; j < int'(DEPTH); j++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_tag", 32'(out_tag), 32'(10 + j));
      tick;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Streaming 1.0 x random: one result per cycle, each equal to the operand
    q.delete();
    in_s = 32'h3F80_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        chk("stream_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2 && i < 22) chk("stream_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (q.size() == 0) chk("stream_extra", 32'(out_valid), 32'd0);
        else               chk("stream_d", out_d, q.pop_front());
      end
      if (i < 20) begin
        rnd    = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        in_t   = rnd;
        in_tag = 5'(i);
        q.push_back(rnd);
      end
      tick;
    end
    chk("stream_all_out", 32'(q.size()), 32'd0);
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Reset with two buffered and one in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_s      = 32'h4000_0000;
    in_t      = 32'h4000_0000;
    for (int i = 1; i <= 3; i++) begin
      in_tag = 5'(i);
      tick;
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(dut.fifo_count), 32'd2);
    chk("pre_rst_inflight", 32'(dut.vld_sr[0]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(dut.fifo_count), 32'd0);
    tick;
    rstn = 1'b1;
    in_valid  = 1'b1;
    in_s      = 32'h4000_0000;
    in_t      = 32'h4040_0000;
    in_tag    = 5'd7;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    tick;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_tag", 32'(out_tag), 32'd7);
    chk("post_rst_d", out_d, 32'h40C0_0000);
    tick;
    chk("post_rst_only_one", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count=DEPTH-1 and at count=1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_s      = 32'h3F80_0000;
    in_t      = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      in_tag = 5'(20 + i);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("pp_fill_count", 32'(dut.fifo_count), 32'd3);
    in_valid = 1'b1;
    in_tag   = 5'd23;
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("pp_hi_before", 32'(dut.fifo_count), 32'd3);
    tick;
    chk("pp_hi_count", 32'(dut.fifo_count), 32'd3);
    chk("pp_hi_tag", 32'(out_tag), 32'd21);
    tick;
    tick;
    chk("pp_lo_count_pre", 32'(dut.fifo_count), 32'd1);
    chk("pp_lo_head_pre", 32'(out_tag), 32'd23);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd24;
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("pp_lo_count", 32'(dut.fifo_count), 32'd1);
    chk("pp_lo_tag", 32'(out_tag), 32'd24);
    tick;
    chk("pp_final_empty", 32'(out_valid), 32'd0);
    chk("pp_final_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul_issue_ctrl.md
FMUL_ISSUE_CTRL -- requirements
Module: fmul_issue_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, giving the destination-register tag width.
REQ-002 The block SHALL have parameter LAT, default 1, giving the cycles from operands driven on fm_s/fm_t to the result valid on fm_d.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the result FIFO entries; DEPTH >= LAT+1.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_s, in_t  in  32  IEEE-754 single operands.
- in_tag  in  TAG_W  destination tag.
- fm_s, fm_t  out  32  operands to the fmul pipeline.
- fm_d  in  32  fmul result.
- fm_ovf, fm_unf  in  1  fmul overflow and underflow flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_d  out  32  result.
- out_tag  out  TAG_W  tag of the result.
- out_exc  out  2  {ovf, unf} of the result.

Function
REQ-005 fm_s/fm_t SHALL equal in_s/in_t combinationally, so the fmul samples them on every edge.
REQ-006 An accepted request SHALL enter the valid/tag shift register vld_sr[LAT-1:0]/tag_sr; non-accepted cycles SHALL shift in valid=0.
REQ-007 When vld_sr[LAT-1] is 1, {fm_d, fm_ovf, fm_unf, tag_sr[LAT-1]} SHALL be pushed into the FIFO that same edge, unconditionally.
REQ-008 in_ready SHALL be 1 iff (fifo_count + popcount(vld_sr)) < DEPTH, so a push never meets a full FIFO.
REQ-009 out_valid SHALL be 1 iff fifo_count != 0; out_d/out_tag/out_exc SHALL be the head entry.
REQ-010 A simultaneous push and pop SHALL leave fifo_count unchanged, with both pointers advancing.
REQ-011 A pop SHALL occur only when out_valid && out_ready; out_ready while empty SHALL have no effect.
REQ-012 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-013 Minimum latency SHALL be LAT+1 edges from acceptance to out_valid, with full throughput of one result per cycle when out_ready=1.
REQ-014 Results SHALL leave in acceptance order; no request SHALL be dropped or duplicated.

Reset
REQ-015 While rstn=0, vld_sr, the FIFO pointers and fifo_count SHALL clear asynchronously; out_valid=0, out_d=0, out_tag=0, out_exc=0, and in_ready=1 after deassertion.
REQ-016 Reset mid-operation SHALL discard all in-flight and buffered results; the first edge after rstn=1 SHALL accept normally.
REQ-017 The FIFO data array SHALL not require reset.

Configuration
REQ-018 With macro FMUL_ISSUE_STICKY_EXC_EN defined, the block SHALL add input exc_clr (1) and output exc_sticky (2).
REQ-019 With that macro defined, exc_sticky SHALL OR in out_exc on every pop, and SHALL clear on rstn=0 or exc_clr=1; exc_clr takes priority over a same-cycle set.
REQ-020 Without the macro, those ports and registers SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-021 Shared package fpu_pkg SHALL hold FP_W=32, the default TAG_W, and the typedef of the packed FIFO entry {d, ovf, unf, tag}.
REQ-022 The FIFO SHALL be one sub-module, fpu_res_fifo (parameterised by DEPTH and entry width); the shift register and credit logic SHALL stay in the top.

Verification
REQ-023 The bench SHALL cover: 0x40000000 x 0x40400000 with tag 3 and out_ready=1 -> out_d=0x40C00000, out_tag=3, out_exc=00, out_valid exactly LAT+1 edges after acceptance.
REQ-024 The bench SHALL cover: 0x7F000000 x 0x7F000000 -> out_d=0x7F800000, out_exc=10; with the macro defined, exc_sticky=10 after the pop and 00 after an exc_clr pulse.
REQ-025 The bench SHALL cover: out_ready=0 with back-to-back requests -> exactly DEPTH accepted, then in_ready=0; raising out_ready drains tags in order with no loss.
REQ-026 The bench SHALL cover: continuous in_valid=1/out_ready=1 with 0x3F800000 x random values -> one result per cycle, each out_d equal to the operand, in_ready held 1.
REQ-027 The bench SHALL cover: rstn pulsed low with 2 results buffered and 1 in flight -> out_valid=0 immediately; a new request after release returns only its own result.
REQ-028 The bench SHALL cover: push and pop in the same cycle at fifo_count=DEPTH-1 and at fifo_count=1 -> fifo_count unchanged, pointers wrap correctly.
